mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Byte-serial controller for the single 8-bit RAM port. It arbitrates between instruction fetch (IF) and the MEM stage.
//  It sequences each 1/2/4-byte access into byte beats and assembles little-endian read words.
//  It sits between if/mem stages and the RAM model.
//  The MEM stage consumes ex's mem_addr/mem_write_data/aluop_o. The IF stage is cancelled by ex's pc_branch_o.
// PARAMETERS
//  ADDR_W   17  RAM byte-address width; bits above ADDR_W-1 of requester addresses ignored
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low (0 = reset)
//  if_req     in   1       IF word-fetch request, held until if_done
//  if_addr    in   32      IF fetch byte address
//  if_cancel  in   1       abort in-flight IF fetch (taken branch/jump)
//  if_data    out  32      fetched word, valid while if_done=1
//  if_done    out  1       one-cycle completion pulse for IF
//  mem_req    in   1       MEM access request, held until mem_done
//  mem_we     in   1       1 = store, 0 = load
//  mem_size   in   2       0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
//  mem_addr   in   32      MEM byte address
//  mem_wdata  in   32      store data, low bytes used
//  mem_rdata  out  32      load data, zero-extended raw bytes, valid while mem_done=1
//  mem_done   out  1       one-cycle completion pulse for MEM
//  ram_addr   out  ADDR_W  RAM byte address
//  ram_we     out  1       RAM write enable
//  ram_dout   out  8       RAM write byte
//  ram_din    in   8       RAM read byte; data for address in cycle k valid in cycle k+1
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, beat counter 0, data regs 0.
//  FSM IDLE/READ/WRITE.
//  IDLE: sample requests not masked by own done pulse this cycle.
//    MEM has priority over IF; latch owner, base, n (1/2/4), we, wdata; go to READ or WRITE with cnt=0.
//  READ, cnt 0..n:
//    cnt<n: ram_addr = base+cnt, ram_we = 0.
//    cnt>=1: capture ram_din into byte cnt-1.
//    cnt==n: owner done<=1, data reg valid, go to IDLE.
//  WRITE, cnt 0..n-1: ram_addr = base+cnt, ram_we = 1, ram_dout = wdata byte cnt.
//    cnt==n-1: done<=1, go to IDLE.
//  Latency, req first high in c0: word read done in c6, byte read in c3, word write in c5, byte write in c2.
//  Back-to-back: next grant is sampled in the done cycle. A requester must drop req in its done cycle.
//  Address wrap: base+cnt truncated to ADDR_W bits; 0x1FFFF + 1 -> 0x00000.
//  if_cancel in READ with owner IF: go to IDLE next cycle, no if_done, captured bytes discarded.
//  if_cancel in IDLE masks if_req that cycle.
//  if_cancel with owner MEM: ignored.
//  if_cancel coincident with if_done: if_done stays high; IF discards.
//  if_cancel and mem_req both high in IDLE: MEM granted.
//  mem_size change mid-access: ignored (latched at grant).
//  Reset mid-access: immediate IDLE. A word write may leave RAM partially written; this is accepted.
//  ram_we is never high in IDLE or READ.
// CONFIGURATION
//  MEM_CTRL_RR_EN defined: after a MEM grant completes, a pending IF request wins the next IDLE arbitration
//    even if mem_req is high; then MEM priority resumes.
//  MEM_CTRL_RR_EN undefined: strict MEM priority; IF may starve under continuous MEM traffic.
// STRUCTURE
//  Shared constants go in defines.v: `MemByte 2'b00, `MemHalf 2'b01, `MemWord 2'b10;
//    state codes `MemIdle/`MemRead/`MemWrite; `ZeroRamAddr reused for ram_addr reset.
//  Single module, no sub-module; beat counter 3 bits, owner flag 1 bit.
// TESTING
//  1 Word fetch: RAM[0x100..0x103] = 13 00 00 93, if_req c0 -> ram_addr 100..103 in c1..c4; if_done c6, if_data 0x93000013.
//  2 Byte store then half load: mem_we=1, size=0, addr 0x20, wdata 0xAB -> ram_we only c1 @0x20, mem_done c2.
//      Then load size=1 @0x20 -> mem_rdata 0x0000xxAB.
//  3 Contention: if_req & mem_req both high c0 -> MEM served first.
//      IF granted in MEM done cycle; ram_addr shows IF base next cycle.
//  4 Cancel: if_req word @0x40, if_cancel pulse c3 -> IDLE c4, no if_done.
//      New if_req @0x80 c4 -> if_done c10 with data from 0x80.
//  5 Wrap: mem word load @0x1FFFE -> ram_addr 1FFFE, 1FFFF, 00000, 00001.
//  6 Reset during word write at c2 (rst=0) -> ram_we 0 immediately, busy 0, done never pulses; rst=1 then normal fetch OK.
//      With MEM_CTRL_RR_EN: two back-to-back mem_req with if_req high -> IF served between them.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: controller states, access-size codes and the size-to-beat-count helper
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  function automatic logic [2:0] beats(input logic [1:0] size);
    return size == MEM_BYTE ? 3'd1 : size == MEM_HALF ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: IF fetch and MEM load/store request/response bus between the pipeline stages and mem_ctrl
interface mem_ctrl_if;
  logic        if_req, if_cancel, if_done, mem_req, mem_we, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
  modport master (
    output if_req, if_addr, if_cancel, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  if_data, if_done, mem_rdata, mem_done
  );
  modport slave (
    input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output if_data, if_done, mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/MEM arbiter for an 8-bit RAM port (clk, rst active-low async, bus slave, ram_*, busy); define MEM_CTRL_RR_EN to give IF the turn after each MEM access
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);
  state_t state, state_n;
  logic [2:0] cnt, n;
  logic [1:0] bi;
  logic [ADDR_W-1:0] base;
  logic [31:0] wdata, rdata;
  logic owner_mem, if_done, mem_done, if_ok, mem_ok, grant, grant_mem, cancel, fin;
  logic unused;
  assign unused = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};
  assign if_ok = bus.if_req && !bus.if_cancel && !if_done;
  assign mem_ok = bus.mem_req && !mem_done;
  assign grant = state == IDLE && (if_ok || mem_ok);
  assign cancel = state == READ && !owner_mem && bus.if_cancel;
  assign fin = state == READ ? (cnt == n && !cancel) : (state == WRITE && cnt == n - 3'd1);
`ifdef MEM_CTRL_RR_EN
  logic if_turn;
  assign grant_mem = mem_ok && !(if_turn && if_ok);
  always_ff @(posedge clk or negedge rst)
    if (!rst) if_turn <= 1'b0;
    else if (fin) if_turn <= owner_mem;
    else if (grant) if_turn <= 1'b0;
`else
  assign grant_mem = mem_ok;
`endif
  always_comb begin
    state_n = grant ? (grant_mem && bus.mem_we ? WRITE : READ) : (cancel || fin) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  assign busy = state != IDLE;
  assign ram_we = state == WRITE;
  assign ram_addr = busy ? base + ADDR_W'(cnt) : '0;
  assign ram_dout = ram_we ? 8'(wdata >> {cnt[1:0], 3'b000}) : 8'd0;
  assign bi = cnt[1:0] - 2'd1;
  assign bus.if_data = rdata;
  assign bus.mem_rdata = rdata;
  assign bus.if_done = if_done;
  assign bus.mem_done = mem_done;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      n         <= '0;
      base      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      owner_mem <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= fin && !owner_mem;
      mem_done <= fin && owner_mem;
      cnt      <= busy ? cnt + 3'd1 : 3'd0;
      if (grant) begin
        owner_mem <= grant_mem;
        n         <= grant_mem ? beats(bus.mem_size) : 3'd4;
        base      <= grant_mem ? bus.mem_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
        wdata     <= bus.mem_wdata;
        rdata     <= '0;
      end else if (state == READ && cnt != 3'd0) rdata[{bi, 3'b000} +: 8] <= ram_din;
    end
endmodule
